prm_edge_query_seq: RTL
=======================

Name: prm_edge_query_seq

Overview:
Initiator side of the obstacle-check interface. It takes a batch request (base configuration code, edge count) and drives one 15-bit query per cycle into the combinational/pipelined edge_mask checker. It collects the returned edge_mask bits into a packed result word and hands that word to the roadmap builder over a valid/ready handshake.

Parameters:
QW, 15, query code width (checker inputs A..O, A = bit 0, O = bit 14)
MAX_EDGES, 32, maximum edges per batch and result word width
CW, 6, width of the count fields (must hold MAX_EDGES)
CHK_LAT, 1, cycles from chk_query_valid to the matching chk_mask sample (0..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  batch request valid
req_ready  out  1  sequencer can accept a request
req_base  in  QW  first query code of the batch
req_count  in  CW  number of edges to check
abort  in  1  synchronous flush of the batch in flight
chk_query  out  QW  query code to the checker (registered)
chk_query_valid  out  1  chk_query is meaningful this cycle
chk_mask  in  1  checker result (1 = edge blocked)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_mask  out  MAX_EDGES  bit k = result for query base+k
rsp_count  out  CW  edges actually checked
rsp_any_blocked  out  1  OR of the valid rsp_mask bits
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE, req_ready = 1.
  - chk_query = 0, chk_query_valid = 0.
  - rsp_valid = 0, rsp_mask = 0, rsp_count = 0, rsp_any_blocked = 0, busy = 0.
  - Internal index and latency pipe cleared.
- IDLE: req_ready = 1.
  - A request is accepted on req_valid & req_ready.
  - Latch base and n = min(req_count, MAX_EDGES), then clear the accumulator.
  - n == 0: go directly to RESP with mask 0, count 0, any_blocked 0.
  - Otherwise go to ISSUE.
- ISSUE: req_ready = 0.
  - Each cycle: chk_query = base + i (mod 2^QW, wraps from 0x7FFF to 0x0000), chk_query_valid = 1, i++.
  - No stalls; one query per cycle.
  - After query n-1 is issued, go to DRAIN.
- Capture: chk_query_valid and i are delayed CHK_LAT cycles.
  - When the delayed valid is high, acc[delayed_i] <= chk_mask.
  - CHK_LAT = 0: sample in the same cycle as the query.
- DRAIN: wait until the last delayed valid has been captured, then go to RESP. With CHK_LAT = 0, DRAIN lasts 0 cycles.
- RESP: rsp_valid = 1.
  - rsp_mask = acc (bits >= n are 0), rsp_count = n, rsp_any_blocked = |acc.
  - Outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE.
  - req_ready rises in the cycle after the handshake (no same-cycle turnaround).
- Latency (CHK_LAT = L, n >= 1): accept at cycle 0, first query at cycle 1, last query at cycle n, rsp_valid at cycle n+L+1.
- abort (highest priority after reset): in any state, go to IDLE next cycle.
  - Drop chk_query_valid and rsp_valid, flush the latency pipe, clear acc.
  - In-flight mask samples are ignored.
  - abort together with a response handshake: abort wins, but the result counts as delivered because rsp_ready was seen.
- Requests arriving while not in IDLE are not accepted (req_ready = 0); the requester holds them.
- busy = (state != IDLE).

Decomposition:
- Package prm_chk_pkg: QW, MAX_EDGES, CW, CHK_LAT defaults; state enum {IDLE, ISSUE, DRAIN, RESP}; query code typedef (logic [QW-1:0]).
- One sub-module, prm_lat_pipe: parameterised delay line of depth CHK_LAT carrying {valid, index}. It is cleared by rst_n and by abort. Depth 0 passes its input straight through.

Test Plan:
All scenarios use a bench checker stub with chk_mask = chk_query[0], registered when CHK_LAT = 1.
- Basic batch, CHK_LAT = 1: base 0x0010, count 4 -> queries 0x10..0x13 on cycles 1..4; rsp_valid at cycle 6; rsp_mask 0x0000000A, rsp_count 4, any_blocked 1.
- Wrap-around: base 0x7FFE, count 4 -> queries 0x7FFE, 0x7FFF, 0x0000, 0x0001; rsp_mask 0x0000000A.
- Zero count and clamp:
  - count 0 -> rsp_valid next cycle, mask 0, count 0, any_blocked 0, no chk_query_valid pulses.
  - count 40 -> exactly 32 queries issued, rsp_count 32.
- Backpressure: rsp_ready held low for 10 cycles -> rsp_mask stable, req_ready 0 throughout; a new req_valid is not accepted until the cycle after the handshake.
- Abort: assert abort at cycle 3 of a count-8 batch -> chk_query_valid low the next cycle; no rsp_valid; the next batch (base 0x0001, count 2) returns rsp_mask 0x1.
- Async reset mid-ISSUE: rst_n low for one partial cycle -> all outputs take reset values immediately; after release the first request behaves as in the basic batch scenario.

Source files
------------

// File: rtl/prm_chk_pkg.sv
// Shared constants, types and helpers for the edge-query sequencer and its latency pipe.
package prm_chk_pkg;

  localparam int unsigned QW              = 15;
  localparam int unsigned MAX_EDGES       = 32;
  localparam int unsigned CW              = 6;
  localparam int unsigned CHK_LAT_DEFAULT = 1;
  localparam int unsigned IW              = $clog2(MAX_EDGES);

  typedef logic [QW-1:0] query_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StResp
  } state_e;

  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cnt);
    return (cnt > CW'(MAX_EDGES)) ? CW'(MAX_EDGES) : cnt;
  endfunction

endpackage

// File: rtl/prm_lat_pipe.sv
// Delay line carrying {valid, index} alongside the checker latency; flush clears it.
module prm_lat_pipe
  import prm_chk_pkg::*;
#(
  parameter int unsigned Depth = CHK_LAT_DEFAULT,
  parameter int unsigned IdxW  = IW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [IdxW-1:0] in_idx,
  output logic            out_valid,
  output logic [IdxW-1:0] out_idx
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, flush};
    assign out_valid   = in_valid;
    assign out_idx     = in_idx;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q;
    logic [IdxW-1:0]  idx_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int i = 0; i < int'(Depth); i++) idx_q[i] <= '0;
      end else if (flush) begin
        valid_q <= '0;
        for (int i = 0; i < int'(Depth); i++) idx_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        idx_q[0]   <= in_idx;
        for (int i = 1; i < int'(Depth); i++) begin
          valid_q[i] <= valid_q[i-1];
          idx_q[i]   <= idx_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_idx   = idx_q[Depth-1];
  end

endmodule

// File: rtl/prm_edge_query_seq.sv
// Issues one checker query per cycle for a batch and returns the packed edge_mask result.
module prm_edge_query_seq
  import prm_chk_pkg::*;
#(
  parameter int unsigned CHK_LAT = CHK_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [QW-1:0]        req_base,
  input  logic [CW-1:0]        req_count,
  input  logic                 abort,
  output logic [QW-1:0]        chk_query,
  output logic                 chk_query_valid,
  input  logic                 chk_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MAX_EDGES-1:0] rsp_mask,
  output logic [CW-1:0]        rsp_count,
  output logic                 rsp_any_blocked,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [CW-1:0]        n_q, n_d;
  logic [IW-1:0]        idx_q, idx_d;
  query_t               query_q, query_d;
  logic                 qvalid_q, qvalid_d;
  logic [MAX_EDGES-1:0] acc_q, acc_d;

  logic                 pipe_valid;
  logic [IW-1:0]        pipe_idx;
  logic                 accept;
  logic                 last_issue;
  logic                 last_capture;
  logic [CW-1:0]        req_n;

  prm_lat_pipe #(
    .Depth (CHK_LAT),
    .IdxW  (IW)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (qvalid_q),
    .in_idx    (idx_q),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  assign req_ready    = (state_q == StIdle) && !abort;
  assign accept       = req_valid && req_ready;
  assign req_n        = clamp_count(req_count);
  assign last_issue   = (CW'(idx_q) + CW'(1)) == n_q;
  assign last_capture = pipe_valid && ((CW'(pipe_idx) + CW'(1)) == n_q);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    query_d  = query_q;
    qvalid_d = 1'b0;
    acc_d    = acc_q;

    if (pipe_valid) acc_d[pipe_idx] = chk_mask;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          n_d     = req_n;
          idx_d   = '0;
          query_d = req_base;
          acc_d   = '0;
          if (req_n == '0) begin
            state_d = StResp;
          end else begin
            qvalid_d = 1'b1;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        if (last_issue) begin
          // Without checker latency the last sample lands this cycle, so DRAIN is skipped.
          state_d = (CHK_LAT == 0) ? StResp : StDrain;
        end else begin
          idx_d    = idx_q + IW'(1);
          query_d  = query_q + query_t'(1);
          qvalid_d = 1'b1;
        end
      end
      StDrain: begin
        if (last_capture) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d  = StIdle;
      qvalid_d = 1'b0;
      idx_d    = '0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= '0;
      idx_q    <= '0;
      query_q  <= '0;
      qvalid_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      query_q  <= query_d;
      qvalid_q <= qvalid_d;
      acc_q    <= acc_d;
    end
  end

  assign chk_query       = query_q;
  assign chk_query_valid = qvalid_q;
  assign rsp_valid       = (state_q == StResp);
  assign rsp_mask        = rsp_valid ? acc_q : '0;
  assign rsp_count       = rsp_valid ? n_q : '0;
  assign rsp_any_blocked = rsp_valid && (|acc_q);
  assign busy            = (state_q != StIdle);

endmodule
